fir_interp_feeder: RTL and testbench

Zero-stuffing sample feeder that sits directly in front of the FIR_FILTER input (`Xn`) when the filter is used as an interpolation filter. It accepts signed samples from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. It drives the filter input every clock at the interpolated rate: one real sample per frame of L cycles, zeros in the remaining L-1 slots. A flush command drains the FIFO, then pads N zero frames so the filter's tap delay line empties cleanly.

---
 rtl/fir_interp_feeder.sv | 110 +++++++++++
 tb/tb_fir_interp_feeder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_interp_feeder.sv
// Zero-stuffing feeder for an interpolating FIR: buffers upstream samples and emits
// one real sample per L-cycle frame (zeros elsewhere), with a drain-and-pad flush.
module fir_interp_feeder #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int L     = 4,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(L),
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1,
  localparam int PADW = $clog2(N * L)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] Xn,
  output logic             xn_valid,
  output logic [PW-1:0]    phase,
  output logic             starve,
  output logic             flush_done,
  output logic [CW-1:0]    count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PAD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PADW-1:0]   pad_q, pad_d;
  logic [PW-1:0]     ph;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              push, pop;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered state/count, never on in_valid.
  assign in_ready   = (state_q == S_RUN) && (count < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (ph == '0) && (count != '0) &&
                      ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign flush_done = (state_q == S_DONE);
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    case (state_q)
      S_RUN:   if (flush) state_d = S_DRAIN;
      S_DRAIN: if (count == '0) begin
                 state_d = S_PAD;
                 pad_d   = PADW'(N * L - 1);
               end
      S_PAD:   if (pad_q == '0) state_d = S_DONE;
               else             pad_d   = pad_q - 1'b1;
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
    end
  end

  // Storage has no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame slot counter free-runs in every state so flush never realigns frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph       <= '0;
      phase    <= '0;
      Xn       <= '0;
      xn_valid <= 1'b0;
      starve   <= 1'b0;
    end else begin
      ph       <= (ph == PW'(L - 1)) ? '0 : ph + 1'b1;
      phase    <= ph;
      Xn       <= pop ? mem[rd_ptr] : '0;
      xn_valid <= pop;
      starve   <= (ph == '0) && (count == '0) && (state_q == S_RUN);
    end
  end

endmodule

// File: tb/tb_fir_interp_feeder.sv
// Bench for fir_interp_feeder: directed scenarios with a queue-based scoreboard
// of expected Xn samples checked by a negedge monitor.
module tb_fir_interp_feeder;
  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int L     = 4;
  localparam int DEPTH = 8;
  localparam logic [1:0] ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_PAD = 2'd2, ST_DONE = 2'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] Xn;
  logic             xn_valid;
  logic [1:0]       phase;
  logic             starve;
  logic             flush_done;
  logic [3:0]       count;
  logic [1:0]       dbg_state;

  logic [WIDTH-1:0] exp_q[$];
  int err_cnt = 0;
  int chk_cnt = 0;
  int peak_cnt = 0;
  logic mon_en = 1'b0;

  fir_interp_feeder #(.WIDTH(WIDTH), .N(N), .L(L), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .Xn(Xn), .xn_valid(xn_valid),
    .phase(phase), .starve(starve), .flush_done(flush_done), .count(count),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial forever #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", err_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (int'(count) > peak_cnt) peak_cnt = int'(count);
      check("in_ready", {31'd0, in_ready}, {31'd0, (dbg_state == ST_RUN) && (count < 4'(DEPTH))});
      if (xn_valid) begin
        check("valid_phase", {30'd0, phase}, 32'd0);
        if (exp_q.size() == 0) check("xn_unexpected", 32'(exp_q.size()), 32'd1);
        else check("xn_data", {16'd0, Xn}, {16'd0, exp_q.pop_front()});
      end else begin
        check("xn_zero", {16'd0, Xn}, 32'd0);
      end
    end
  end

  // Driver tasks (called at posedge+1)
  task automatic push(input logic [WIDTH-1:0] v);
    int t = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) check("push_timeout", {31'd0, in_ready}, 32'd1);
    else exp_q.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic align(input int p);
    int t = 0;
    @(posedge clk); #1;
    while (int'(phase) != p && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("align", {30'd0, phase}, 32'(p));
  endtask

  task automatic wait_empty();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk); t++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int pad_n, bad_rdy, bad_starve, done_n, st_n, t;
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_xn", {16'd0, Xn}, 32'd0);
    check("rst_xn_valid", {31'd0, xn_valid}, 32'd0);
    check("rst_phase", {30'd0, phase}, 32'd0);
    check("rst_starve", {31'd0, starve}, 32'd0);
    check("rst_flush_done", {31'd0, flush_done}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_state", {30'd0, dbg_state}, 32'(ST_RUN));
    rst = 1'b0;
    mon_en = 1'b1;

    // Four back-to-back samples, first accepted at slot 1
    align(0);
    peak_cnt = 0;
    push(16'd100); push(16'd200); push(16'hFFCE); push(16'd25);
    wait_empty();
    check("t1_peak_count", 32'(peak_cnt), 32'd3);

    // Burst past full
    align(0);
    peak_cnt = 0;
    for (int i = 0; i < 14; i++) push(16'($urandom_range(0, 65535)));
    wait_empty();
    check("t2_peak_count", 32'(peak_cnt), 32'(DEPTH));

    // Flush with two samples queued
    push(16'd100); push(16'd200);
    pulse_flush();
    pad_n = 0; bad_rdy = 0; bad_starve = 0; done_n = 0; t = 0;
    while (done_n == 0 && t < 200) begin
      @(negedge clk); t++;
      if (dbg_state == ST_PAD) pad_n++;
      if (dbg_state != ST_RUN && in_ready) bad_rdy++;
      if ((dbg_state == ST_PAD || dbg_state == ST_DONE) && starve) bad_starve++;
      if (flush_done) done_n++;
    end
    check("t3_flush_done_seen", 32'(done_n), 32'd1);
    check("t3_emitted", 32'(exp_q.size()), 32'd0);
    check("t3_pad_cycles", 32'(pad_n), 32'(N * L));
    check("t3_ready_low", 32'(bad_rdy), 32'd0);
    check("t3_no_starve_pad", 32'(bad_starve), 32'd0);
    @(negedge clk);
    check("t3_done_once", {31'd0, flush_done}, 32'd0);
    check("t3_ready_back", {31'd0, in_ready}, 32'd1);

    // Starvation in RUN
    st_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t4_starve_slot", {31'd0, starve}, {31'd0, phase == 2'd0});
      if (starve) st_n++;
    end
    check("t4_starve_count", 32'(st_n), 32'd3);
    @(posedge clk); #1;

    // Reset during PAD
    push(16'd11); push(16'd22); push(16'd33);
    pulse_flush();
    t = 0;
    while (dbg_state != ST_PAD && t < 100) begin
      @(negedge clk); t++;
    end
    check("t5_reach_pad", {30'd0, dbg_state}, 32'(ST_PAD));
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t5_xn", {16'd0, Xn}, 32'd0);
    check("t5_count", {28'd0, count}, 32'd0);
    check("t5_state", {30'd0, dbg_state}, 32'(ST_RUN));
    check("t5_in_ready", {31'd0, in_ready}, 32'd1);
    check("t5_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    push(16'd77);
    wait_empty();

    // Push and pop on the same edge at count 1
    align(2);
    push(16'd5); push(16'd6);
    check("t6_count", {28'd0, count}, 32'd1);
    check("t6_xn_valid", {31'd0, xn_valid}, 32'd1);
    check("t6_xn", {16'd0, Xn}, 32'd5);
    wait_empty();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
